// File: rtl/branch_predictor_pkg.sv
// Shared constants and types for the branch target buffer.
package branch_predictor_pkg;

    // Default PC/target width of the 16-bit datapath.
    localparam int BP_WORD_SIZE = 16;

    // Prediction modes.
    localparam int BP_MODE_NONE    = 0;
    localparam int BP_MODE_BIMODAL = 1;
    localparam int BP_MODE_STATIC  = 2;

    // What a resolved instruction does to its table entry.
    typedef enum logic [1:0] {
        UPD_NONE  = 2'd0,
        UPD_TRAIN = 2'd1,
        UPD_ALLOC = 2'd2,
        UPD_INVAL = 2'd3
    } upd_kind_e;

    // A prediction is wrong if the direction differs, or if both say taken
    // but the carried target is not the real one.
    function automatic logic is_mispredict(input logic pred_taken,
                                           input logic actual_taken,
                                           input logic target_match);
        return (pred_taken != actual_taken) || (actual_taken && !target_match);
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Lookup, training and statistics signals between the pipeline and the predictor.
interface branch_predictor_if
    import branch_predictor_pkg::*;
#(
    parameter int WIDTH = BP_WORD_SIZE
) ();
    logic             lookup_valid;
    logic [WIDTH-1:0] lookup_pc;
    logic             pred_hit;
    logic             pred_taken;
    logic [WIDTH-1:0] pred_target;
    logic             upd_valid;
    logic [WIDTH-1:0] upd_pc;
    logic             upd_is_branch;
    logic             upd_is_jump;
    logic             upd_taken;
    logic [WIDTH-1:0] upd_target;
    logic             upd_pred_taken;
    logic [WIDTH-1:0] upd_pred_target;
    logic             flush_all;
    logic [WIDTH-1:0] hit_cnt;
    logic [WIDTH-1:0] mispred_cnt;

    // Pipeline side: drives lookups and resolutions.
    modport master (
        output lookup_valid, lookup_pc,
        output upd_valid, upd_pc, upd_is_branch, upd_is_jump, upd_taken,
        output upd_target, upd_pred_taken, upd_pred_target, flush_all,
        input  pred_hit, pred_taken, pred_target, hit_cnt, mispred_cnt
    );

    // Predictor side.
    modport slave (
        input  lookup_valid, lookup_pc,
        input  upd_valid, upd_pc, upd_is_branch, upd_is_jump, upd_taken,
        input  upd_target, upd_pred_taken, upd_pred_target, flush_all,
        output pred_hit, pred_taken, pred_target, hit_cnt, mispred_cnt
    );
endinterface

// File: rtl/branch_predictor_sat_counter.sv
// Next-value logic for a saturating direction counter, shared by the
// train-on-hit and allocate-on-miss paths.
module bp_sat_counter
#(
    parameter int CTR_BITS = 2
) (
    input  logic [CTR_BITS-1:0] ctr,
    input  logic                inc,
    input  logic                set_max,
    input  logic                set_weak,
    output logic [CTR_BITS-1:0] ctr_next
);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);

    // Forced values take priority; otherwise step one toward the outcome and hold at the rails.
    always_comb begin
        ctr_next = ctr;
        if (set_max) begin
            ctr_next = CTR_MAX;
        end else if (set_weak) begin
            ctr_next = CTR_WEAK;
        end else if (inc) begin
            if (ctr != CTR_MAX) begin
                ctr_next = ctr + CTR_BITS'(1);
            end else begin
                ctr_next = ctr;
            end
        end else begin
            if (ctr != {CTR_BITS{1'b0}}) begin
                ctr_next = ctr - CTR_BITS'(1);
            end else begin
                ctr_next = ctr;
            end
        end
    end
endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry direction counters.
// Lookup is combinational from the table registers; training happens on the
// clock edge from the ID-stage resolution. reset_n is active-high.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int WORD_SIZE = BP_WORD_SIZE,
    parameter int ENTRIES   = 16,
    parameter int CTR_BITS  = 2,
    parameter int MODE      = BP_MODE_BIMODAL
) (
    input logic               clk,
    input logic               reset_n,
    branch_predictor_if.slave bus
);
    localparam int IDX = $clog2(ENTRIES);
    localparam int TAG = WORD_SIZE - IDX;

    // Flat register arrays so the whole table clears on asynchronous reset.
    logic                valid_r  [ENTRIES];
    logic [TAG-1:0]      tag_r    [ENTRIES];
    logic [WORD_SIZE-1:0] target_r [ENTRIES];
    logic [CTR_BITS-1:0] ctr_r    [ENTRIES];

    logic [WORD_SIZE-1:0] hit_cnt_r;
    logic [WORD_SIZE-1:0] mispred_cnt_r;

    logic [IDX-1:0]       lk_idx_s;
    logic                 lk_hit_s;
    logic                 lk_taken_s;
    logic [WORD_SIZE-1:0] lk_target_s;

    logic [IDX-1:0]       upd_idx_s;
    logic                 upd_hit_s;
    logic                 upd_ctrl_s;
    logic                 upd_t_s;
    logic                 mispred_s;
    upd_kind_e            upd_kind_s;
    logic [CTR_BITS-1:0]  upd_ctr_cur_s;
    logic [CTR_BITS-1:0]  upd_ctr_new_s;

    // Combinational lookup; forced quiet while reset is held.
    always_comb begin
        lk_idx_s    = bus.lookup_pc[IDX-1:0];
        lk_hit_s    = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == bus.lookup_pc[WORD_SIZE-1:IDX])
                      && !reset_n;
        case (MODE)
            BP_MODE_NONE:    lk_taken_s = 1'b0;
            BP_MODE_BIMODAL: lk_taken_s = lk_hit_s && ctr_r[lk_idx_s][CTR_BITS-1];
            BP_MODE_STATIC:  lk_taken_s = lk_hit_s;
            default:         lk_taken_s = 1'b0;
        endcase
        if (lk_taken_s) begin
            lk_target_s = target_r[lk_idx_s];
        end else begin
            lk_target_s = {WORD_SIZE{1'b0}};
        end
    end

    assign bus.pred_hit    = lk_hit_s;
    assign bus.pred_taken  = lk_taken_s;
    assign bus.pred_target = lk_target_s;
    assign bus.hit_cnt     = hit_cnt_r;
    assign bus.mispred_cnt = mispred_cnt_r;

    // Classify the resolved instruction against the current table contents.
    always_comb begin
        upd_idx_s     = bus.upd_pc[IDX-1:0];
        upd_hit_s     = valid_r[upd_idx_s] && (tag_r[upd_idx_s] == bus.upd_pc[WORD_SIZE-1:IDX]);
        upd_ctrl_s    = bus.upd_is_branch || bus.upd_is_jump;
        upd_t_s       = bus.upd_taken || bus.upd_is_jump;
        upd_ctr_cur_s = ctr_r[upd_idx_s];
        upd_kind_s    = UPD_NONE;
        if (!bus.upd_valid) begin
            upd_kind_s = UPD_NONE;
        end else if (upd_hit_s) begin
            // A hit on a non-control instruction is an alias; drop the entry.
            upd_kind_s = upd_ctrl_s ? UPD_TRAIN : UPD_INVAL;
        end else if (upd_ctrl_s && upd_t_s) begin
            upd_kind_s = UPD_ALLOC;
        end else begin
            upd_kind_s = UPD_NONE;
        end
        mispred_s = bus.upd_valid && upd_ctrl_s &&
                    is_mispredict(bus.upd_pred_taken, upd_t_s,
                                  bus.upd_pred_target == bus.upd_target);
    end

    bp_sat_counter #(
        .CTR_BITS (CTR_BITS)
    ) u_sat_counter (
        .ctr      (upd_ctr_cur_s),
        .inc      (upd_t_s),
        .set_max  (bus.upd_is_jump),
        .set_weak (upd_kind_s == UPD_ALLOC),
        .ctr_next (upd_ctr_new_s)
    );

    // Table state: flush wins over a same-cycle update; only the addressed entry trains.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i]  <= 1'b0;
                tag_r[i]    <= {TAG{1'b0}};
                target_r[i] <= {WORD_SIZE{1'b0}};
                ctr_r[i]    <= {CTR_BITS{1'b0}};
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (bus.flush_all) begin
                    valid_r[i] <= 1'b0;
                    ctr_r[i]   <= {CTR_BITS{1'b0}};
                end else if (upd_idx_s == IDX'(i)) begin
                    case (upd_kind_s)
                        UPD_TRAIN: begin
                            ctr_r[i] <= upd_ctr_new_s;
                            if (upd_t_s) begin
                                target_r[i] <= bus.upd_target;
                            end
                        end
                        UPD_ALLOC: begin
                            valid_r[i]  <= 1'b1;
                            tag_r[i]    <= bus.upd_pc[WORD_SIZE-1:IDX];
                            target_r[i] <= bus.upd_target;
                            ctr_r[i]    <= upd_ctr_new_s;
                        end
                        UPD_INVAL: begin
                            valid_r[i] <= 1'b0;
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    // Saturating debug statistics; unaffected by flush.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            hit_cnt_r     <= {WORD_SIZE{1'b0}};
            mispred_cnt_r <= {WORD_SIZE{1'b0}};
        end else begin
            if (bus.lookup_valid && lk_hit_s && (hit_cnt_r != {WORD_SIZE{1'b1}})) begin
                hit_cnt_r <= hit_cnt_r + WORD_SIZE'(1);
            end
            if (mispred_s && (mispred_cnt_r != {WORD_SIZE{1'b1}})) begin
                mispred_cnt_r <= mispred_cnt_r + WORD_SIZE'(1);
            end
        end
    end
endmodule
